// File: rtl/baud_gen_frac.sv
`timescale 1ns / 1ps
// rtl/baud_gen_frac.sv - fractional baud tick generator with oversample, bit and mid-bit strobes
// Integer divisor plus first-order fractional accumulator; divisor changes land on tick boundaries.
module baud_gen_frac #(
    parameter int DIV_W        = 16,
    parameter int FRAC_W       = 4,
    parameter int OSR          = 16,
    parameter int DEFAULT_INT  = 651,
    parameter int DEFAULT_FRAC = 1
) (
    input  logic              clk_100MHz,
    input  logic              reset_n,
    input  logic              en,
    input  logic              restart,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DIV_W-1:0]  cfg_int,
    input  logic [FRAC_W-1:0] cfg_frac,
    output logic              cfg_err,
    output logic              os_tick,
    output logic              bit_tick,
    output logic              mid_tick
);

    localparam int OS_W = (OSR > 1) ? $clog2(OSR) : 1;
    localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OSR - 1);
    localparam logic [OS_W-1:0]  OS_MID  = OS_W'(OSR / 2 - 1);
    localparam logic [OS_W-1:0]  OS_ONE  = OS_W'(1);
    localparam logic [DIV_W:0]   CNT_ONE = (DIV_W + 1)'(1);
    localparam logic [DIV_W-1:0] MIN_INT = DIV_W'(2);

    logic [DIV_W:0]    r_cnt;
    logic [DIV_W:0]    r_cur_lim;
    logic [FRAC_W-1:0] r_acc;
    logic [OS_W-1:0]   r_os_cnt;
    logic [DIV_W-1:0]  r_act_int;
    logic [FRAC_W-1:0] r_act_frac;
    logic [DIV_W-1:0]  r_sh_int;
    logic [FRAC_W-1:0] r_sh_frac;
    logic              r_pend;
    logic              r_cfg_err;

    logic              w_os_hit;
    logic              w_apply;
    logic              w_accept;
    logic              w_bad;
    logic [DIV_W-1:0]  w_use_int;
    logic [FRAC_W-1:0] w_use_frac;
    logic [FRAC_W:0]   w_sum;
    logic [DIV_W:0]    w_next_lim;

    assign w_os_hit = (r_cnt == (r_cur_lim - CNT_ONE));
    assign os_tick  = reset_n & en & ~restart & w_os_hit;
    assign bit_tick = os_tick & (r_os_cnt == OS_LAST);
    assign mid_tick = os_tick & (r_os_cnt == OS_MID);

    // A pending divisor is taken at the next period boundary, or at once when idle/re-phasing.
    assign w_apply    = r_pend & (~en | restart | os_tick);
    assign w_use_int  = w_apply ? r_sh_int  : r_act_int;
    assign w_use_frac = w_apply ? r_sh_frac : r_act_frac;
    assign w_sum      = {1'b0, r_acc} + {1'b0, w_use_frac};
    assign w_next_lim = {1'b0, w_use_int} + {{DIV_W{1'b0}}, w_sum[FRAC_W]};

    assign w_accept  = cfg_valid & ~r_pend;
    assign w_bad     = (cfg_int < MIN_INT);
    assign cfg_ready = ~r_pend;
    assign cfg_err   = r_cfg_err;

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_cur_lim  <= (DIV_W + 1)'(DEFAULT_INT);
            r_acc      <= '0;
            r_os_cnt   <= '0;
            r_act_int  <= DIV_W'(DEFAULT_INT);
            r_act_frac <= FRAC_W'(DEFAULT_FRAC);
            r_sh_int   <= DIV_W'(DEFAULT_INT);
            r_sh_frac  <= FRAC_W'(DEFAULT_FRAC);
            r_pend     <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_cfg_err <= w_accept & w_bad;

            if (w_apply) begin
                r_act_int  <= r_sh_int;
                r_act_frac <= r_sh_frac;
                r_pend     <= 1'b0;
            end else if (w_accept && !w_bad) begin
                r_sh_int  <= cfg_int;
                r_sh_frac <= cfg_frac;
                r_pend    <= 1'b1;
            end

            // With en low the limit is left alone so the frozen period resumes unchanged.
            if (en) begin
                if (restart) begin
                    r_cnt     <= '0;
                    r_acc     <= '0;
                    r_os_cnt  <= '0;
                    r_cur_lim <= {1'b0, w_use_int};
                end else if (w_os_hit) begin
                    r_cnt     <= '0;
                    r_acc     <= w_sum[FRAC_W-1:0];
                    r_cur_lim <= w_next_lim;
                    r_os_cnt  <= (r_os_cnt == OS_LAST) ? '0 : r_os_cnt + OS_ONE;
                end else begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_baud_gen_frac.sv
`timescale 1ns / 1ps
// tb/tb_baud_gen_frac.sv - self-checking bench for baud_gen_frac
module tb_baud_gen_frac;

    localparam int FD = 16;

    logic        clk_100MHz;
    logic        reset_n;
    logic        en;
    logic        restart;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_int;
    logic [3:0]  cfg_frac;
    logic        cfg_err;
    logic        os_tick;
    logic        bit_tick;
    logic        mid_tick;

    baud_gen_frac dut (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .en         (en),
        .restart    (restart),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_int    (cfg_int),
        .cfg_frac   (cfg_frac),
        .cfg_err    (cfg_err),
        .os_tick    (os_tick),
        .bit_tick   (bit_tick),
        .mid_tick   (mid_tick)
    );

    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    typedef struct {
        int per;
        bit mid;
        bit bt;
    } exp_t;

    typedef struct {
        int ci;
        int cf;
        bit err;
        int ei;
        int ef;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[6];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Period k after a phase-aligned start is int plus the carries of k*frac/2^FRAC_W.
    task automatic push_periods(input int n, input int ei, input int ef, input int s);
        for (int k = 1; k <= n; k++) begin
            exp_t e;
            int   os;
            e.per = (k == 1) ? ei : ei + ((k - 1) * ef) / FD - ((k - 2) * ef) / FD;
            os    = (s + k - 1) % 16;
            e.mid = (os == 7);
            e.bt  = (os == 15);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_tick(output int n, output bit m, output bit b, input bit ready_low);
        bit done;
        done = 1'b0;
        n    = 0;
        m    = 1'b0;
        b    = 1'b0;
        for (int i = 0; i < 5000 && !done; i++) begin
            @(negedge clk_100MHz);
            n++;
            if (ready_low) chk("cfg_ready_pending", int'(cfg_ready), 0);
            if (os_tick) begin
                m    = mid_tick;
                b    = bit_tick;
                done = 1'b1;
            end else begin
                chk("stray_strobe", int'(mid_tick | bit_tick), 0);
            end
        end
        if (!done) begin
            chk("tick_timeout", 0, 1);
            n = -1;
        end
    endtask

    task automatic check_next(input bit ready_low);
        int   n;
        bit   m;
        bit   b;
        exp_t e;
        wait_tick(n, m, b, ready_low);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk("period", n, e.per);
            chk("mid_tick", int'(m), int'(e.mid));
            chk("bit_tick", int'(b), int'(e.bt));
        end
    endtask

    task automatic offer(input int ci, input int cf, input bit exp_err, input bit exp_ready);
        chk("cfg_ready_before", int'(cfg_ready), 1);
        cfg_valid = 1'b1;
        cfg_int   = 16'(ci);
        cfg_frac  = 4'(cf);
        @(negedge clk_100MHz);
        chk("cfg_err", int'(cfg_err), int'(exp_err));
        chk("cfg_ready_after", int'(cfg_ready), int'(exp_ready));
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        #1;
        chk("restart_masks_ticks", int'(os_tick | mid_tick | bit_tick), 0);
        @(posedge clk_100MHz);
        #1;
        restart = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{10,  8, 1'b0, 10,  8};
        vecs[1] = '{1,   3, 1'b1, 10,  8};
        vecs[2] = '{2,  15, 1'b0, 2,  15};
        vecs[3] = '{0,   0, 1'b1, 2,  15};
        vecs[4] = '{300, 3, 1'b0, 300, 3};
        vecs[5] = '{7,   5, 1'b0, 7,   5};

        reset_n   = 1'b0;
        en        = 1'b1;
        restart   = 1'b0;
        cfg_valid = 1'b0;
        cfg_int   = '0;
        cfg_frac  = '0;

        repeat (3) @(posedge clk_100MHz);
        #1;
        chk("reset_ticks", int'(os_tick | mid_tick | bit_tick), 0);
        chk("reset_cfg_ready", int'(cfg_ready), 1);
        chk("reset_cfg_err", int'(cfg_err), 0);
        reset_n = 1'b1;

        push_periods(30, 651, 1, 0);
        repeat (30) check_next(1'b0);

        foreach (vecs[i]) begin
            offer(vecs[i].ci, vecs[i].cf, vecs[i].err, vecs[i].err);
            pulse_restart();
            push_periods(20, vecs[i].ei, vecs[i].ef, 0);
            repeat (20) check_next(1'b0);
        end

        // Rejected offer, then a divisor that waits for the in-flight 11-cycle period.
        offer(10, 8, 1'b0, 1'b0);
        pulse_restart();
        push_periods(2, 10, 8, 0);
        repeat (2) check_next(1'b0);
        offer(1, 0, 1'b1, 1'b1);
        offer(4, 0, 1'b0, 1'b0);
        exp_q.push_back('{9, 1'b0, 1'b0});
        check_next(1'b1);
        @(posedge clk_100MHz);
        #1;
        chk("cfg_ready_after_apply", int'(cfg_ready), 1);
        push_periods(6, 4, 0, 3);
        repeat (6) check_next(1'b0);

        // Re-phase at cnt=2, os_cnt=9.
        repeat (3) begin
            @(negedge clk_100MHz);
            chk("pre_restart_no_tick", int'(os_tick), 0);
        end
        pulse_restart();
        push_periods(16, 4, 0, 0);
        repeat (16) check_next(1'b0);

        // Freeze on the tick cycle itself; a divisor offered meanwhile lands at once.
        repeat (3) begin
            @(negedge clk_100MHz);
            chk("pre_freeze_no_tick", int'(os_tick), 0);
        end
        @(posedge clk_100MHz);
        #1;
        en = 1'b0;
        #1;
        chk("en_gates_tick", int'(os_tick), 0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_100MHz);
            chk("frozen_ticks", int'(os_tick | mid_tick | bit_tick), 0);
            if (i == 10) begin
                cfg_valid = 1'b1;
                cfg_int   = 16'd6;
                cfg_frac  = 4'd0;
            end
            if (i == 11) begin
                chk("frozen_cfg_pending", int'(cfg_ready), 0);
                cfg_valid = 1'b0;
            end
            if (i == 12) chk("frozen_cfg_applied", int'(cfg_ready), 1);
        end
        @(posedge clk_100MHz);
        #1;
        en = 1'b1;
        exp_q.push_back('{1, 1'b0, 1'b0});
        push_periods(3, 6, 0, 1);
        repeat (4) check_next(1'b0);

        // Async reset while a tick is showing and a divisor is pending.
        offer(8, 0, 1'b0, 1'b0);
        repeat (4) begin
            @(negedge clk_100MHz);
            chk("pre_reset_no_tick", int'(os_tick), 0);
        end
        @(posedge clk_100MHz);
        #2;
        chk("pre_reset_tick", int'(os_tick), 1);
        chk("pre_reset_ready", int'(cfg_ready), 0);
        reset_n = 1'b0;
        #1;
        chk("async_reset_ticks", int'(os_tick | mid_tick | bit_tick), 0);
        chk("async_reset_ready", int'(cfg_ready), 1);
        chk("async_reset_err", int'(cfg_err), 0);
        repeat (2) @(posedge clk_100MHz);
        #1;
        reset_n = 1'b1;
        push_periods(2, 651, 1, 0);
        repeat (2) check_next(1'b0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/baud_gen_frac.md
Name: baud_gen_frac

Overview:
- Runtime-programmable fractional baud tick generator for the UART system.
- Produces three tick strobes:
  - an oversample tick (OSR x baud),
  - a 1x bit tick for the transmitter,
  - a mid-bit tick for receiver sampling.
- Divisor = integer part + fractional part (first-order accumulator) to cut baud error at the 100 MHz clock.
- Divisor update uses a valid/ready handshake, applied glitch-free on a tick boundary. A restart input re-phases the ticks to an RX start-bit edge.

Parameters:
- DIV_W, 16, width of integer divisor field.
- FRAC_W, 4, width of fractional divisor field (fraction = div_frac / 2^FRAC_W).
- OSR, 16, oversample ticks per bit. Must be even and >= 4.
- DEFAULT_INT, 651, integer divisor after reset (9600 baud x16 at 100 MHz).
- DEFAULT_FRAC, 1, fractional divisor after reset.

Ports:
- clk_100MHz  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  1 = run. 0 = freeze all counters and hold ticks low.
- restart  in  1  synchronous re-phase pulse.
- cfg_valid  in  1  new divisor offered.
- cfg_ready  out  1  divisor can be accepted.
- cfg_int  in  DIV_W  new integer divisor.
- cfg_frac  in  FRAC_W  new fractional divisor.
- cfg_err  out  1  one-cycle pulse: offered cfg_int < 2, rejected.
- os_tick  out  1  oversample tick, one cycle wide.
- bit_tick  out  1  1x bit tick, one cycle wide.
- mid_tick  out  1  mid-bit tick, one cycle wide.

Behaviour:
- State:
  - cnt: DIV_W+1 bits.
  - cur_lim: DIV_W+1 bits.
  - acc: FRAC_W bits.
  - os_cnt: clog2(OSR) bits.
  - act_int, act_frac: active divisor.
  - shadow registers plus a pend flag.
- Reset (async, reset_n=0): cnt=0, acc=0, os_cnt=0, act_int=DEFAULT_INT, act_frac=DEFAULT_FRAC, cur_lim=DEFAULT_INT, pend=0. Outputs: os_tick=0, bit_tick=0, mid_tick=0, cfg_err=0, cfg_ready=1.
- Tick outputs are combinational from registered state. With en=1 and restart=0:
  - os_tick = (cnt == cur_lim-1).
  - bit_tick = os_tick & (os_cnt == OSR-1).
  - mid_tick = os_tick & (os_cnt == OSR/2-1).
- Counter step, with en=1 and restart=0:
  - Non-tick cycle: cnt++.
  - os_tick cycle: cnt<=0; {c,acc} <= acc + act_frac (FRAC_W+1-bit sum, c = carry); cur_lim <= act_int + c (zero-extended); os_cnt wraps OSR-1 -> 0, else increments.
- Net effect: oversample period averages act_int + act_frac/2^FRAC_W cycles. The first period after reset or restart is exactly act_int.
- Config handshake:
  - cfg_ready = ~pend.
  - Accept when cfg_valid & cfg_ready.
  - If cfg_int < 2: not stored, cfg_err pulses the next cycle, pend stays 0.
  - Otherwise: shadow <= cfg, pend <= 1.
- Applying a pending config:
  - Applied on the next os_tick cycle. In that cycle act_* <= shadow, cur_lim <= shadow_int + c, with c computed using the new frac. Then pend <= 0.
  - If en=0 or restart=1, applied on the next clock instead.
  - The period in progress always completes with the old limit. No runt or stretched tick beyond one old period.
- restart=1 (with en=1): cnt=0, acc=0, os_cnt=0, cur_lim=act_int (or shadow_int if applying). No ticks asserted that cycle; it overrides a coincident tick. The first os_tick follows cur_lim cycles after restart deasserts.
- en=0: all state holds, ticks 0, config handshake still operates.
- restart is ignored while en=0.
- Reset mid-period clears everything immediately; no tick is emitted while reset_n=0.

Test Plan:
- Reset defaults, en=1 for 20000 cycles:
  - First os_tick at cycle 651 after reset release.
  - Subsequent periods 651 except every 16th period, which is 652.
  - bit_tick every 16th os_tick; mid_tick on os_cnt=7.
- cfg_int=10, cfg_frac=8 accepted:
  - Current period finishes, then periods run 10,10,11,10,11 (alternating 10/11).
  - Any 16 consecutive periods from the second onward sum to 168 cycles.
- Offer cfg_int=1:
  - cfg_err pulses one cycle; divisor unchanged; cfg_ready stays 1.
  - Then offer cfg_int=4, cfg_frac=0: cfg_ready low until the next os_tick; periods 4 thereafter.
- cfg_int=4, frac=0, pulse restart at cnt=2, os_cnt=9:
  - No tick that cycle.
  - Next os_tick exactly 4 cycles after restart; mid_tick on the 8th os_tick; bit_tick on the 16th.
- en=0 for 50 cycles mid-period:
  - Ticks held 0; counters resume from the frozen value.
  - Remaining cycles to os_tick unchanged.
- Assert reset_n low asynchronously mid-period:
  - Outputs 0 and cfg_ready 1 within the same cycle.
  - After release, first os_tick at DEFAULT_INT cycles.
